// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: mode-0 SPI slave front end driving a downstream serial shift register.
// Optional SPI_SCK_FILTER_EN adds a 3-sample majority filter on the synchronized SCK.
module spi_slave_frontend #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_flag,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       sr_so,
    output logic       sr_sel,
    output logic       sr_si,
    output logic       sr_reset,
    output logic       active,
    output logic       word_done,
    output logic [7:0] word_count,
    output logic       frame_err
);
    localparam int CW = $clog2(N);

    logic [SYNC_STAGES-1:0] sck_s_q, cs_s_q, mosi_s_q, flush_q;
    logic                   sck_h_q, cs_h_q, armed_q, armed_d;
    logic [CW-1:0]          bit_q, bit_d;
    logic [7:0]             wc_q, wc_d;
    logic                   act_q, act_d, sel_q, sel_d, si_q, si_d, srst_q, srst_d, srst2_q;
    logic                   wd_q, wd_d, ferr_q, ferr_d, miso_q, miso_d;
    logic                   sck_f, cs_sync, cs_fall, cs_rise, sck_rise, sck_fall, shift, bit_last;

`ifdef SPI_SCK_FILTER_EN
    logic [2:0] flt_q;
    always_ff @(posedge clk) begin
        if (reset_flag) flt_q <= '0;
        else            flt_q <= {flt_q[1:0], sck_s_q[SYNC_STAGES-1]};
    end
    assign sck_f = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
`else
    assign sck_f = sck_s_q[SYNC_STAGES-1];
`endif

    assign cs_sync  = cs_s_q[SYNC_STAGES-1];
    // A fall is only trusted once CS has been seen high after reset, so a reset
    // with CS held low cannot fabricate a session start.
    assign cs_fall  = armed_q & cs_h_q & ~cs_sync;
    assign cs_rise  = ~cs_h_q & cs_sync;
    assign sck_rise = sck_f & ~sck_h_q;
    assign sck_fall = ~sck_f & sck_h_q;
    assign shift    = act_q & sck_rise & ~cs_fall;
    assign bit_last = bit_q == CW'(N - 1);

    always_comb begin
        armed_d = armed_q | (flush_q[SYNC_STAGES-1] & cs_sync);
        bit_d   = bit_q;
        wc_d    = wc_q;
        act_d   = act_q;
        sel_d   = 1'b0;
        si_d    = si_q;
        srst_d  = 1'b0;
        wd_d    = 1'b0;
        ferr_d  = ferr_q;
        if (cs_fall) begin
            act_d  = 1'b1;
            bit_d  = '0;
            wc_d   = '0;
            ferr_d = 1'b0;
            srst_d = 1'b1;
        end else begin
            if (shift) begin
                sel_d = 1'b1;
                si_d  = mosi_s_q[SYNC_STAGES-1];
                bit_d = bit_last ? '0 : bit_q + 1'b1;
                wd_d  = bit_last;
                wc_d  = (bit_last && wc_q != 8'hFF) ? wc_q + 8'd1 : wc_q;
            end
            if (act_q && cs_rise) begin
                act_d  = 1'b0;
                ferr_d = ferr_q | (bit_d != '0);
            end
        end
        miso_d = (srst2_q || (act_q && sck_fall && !cs_fall)) ? sr_so : miso_q;
    end

    always_ff @(posedge clk) begin
        if (reset_flag) begin
            sck_s_q  <= '0;
            cs_s_q   <= '1;
            mosi_s_q <= '0;
            flush_q  <= '0;
            sck_h_q  <= 1'b0;
            cs_h_q   <= 1'b1;
            armed_q  <= 1'b0;
            bit_q    <= '0;
            wc_q     <= '0;
            act_q    <= 1'b0;
            sel_q    <= 1'b0;
            si_q     <= 1'b0;
            srst_q   <= 1'b0;
            srst2_q  <= 1'b0;
            wd_q     <= 1'b0;
            ferr_q   <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            sck_s_q  <= {sck_s_q[SYNC_STAGES-2:0], spi_sck};
            cs_s_q   <= {cs_s_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_s_q <= {mosi_s_q[SYNC_STAGES-2:0], spi_mosi};
            flush_q  <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sck_h_q  <= sck_f;
            cs_h_q   <= cs_sync;
            armed_q  <= armed_d;
            bit_q    <= bit_d;
            wc_q     <= wc_d;
            act_q    <= act_d;
            sel_q    <= sel_d;
            si_q     <= si_d;
            srst_q   <= srst_d;
            srst2_q  <= srst_q;
            wd_q     <= wd_d;
            ferr_q   <= ferr_d;
            miso_q   <= miso_d;
        end
    end

    assign spi_miso   = miso_q;
    assign sr_sel     = sel_q;
    assign sr_si      = si_q;
    assign sr_reset   = srst_q;
    assign active     = act_q;
    assign word_done  = wd_q;
    assign word_count = wc_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb_spi_slave_frontend: directed checks of the SPI slave front end with a downstream shift-register model.
module tb_spi_slave_frontend;
    localparam int S = 2;

    logic       clk = 1'b0, reset_flag = 1'b1;
    logic       spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, sr_so, sr_sel, sr_si, sr_reset, active, word_done, frame_err;
    logic [7:0] word_count;

    logic [7:0] sr_q = 8'hFF, preload = 8'hFF, si_log = 8'h00, miso_log = 8'h00;
    int         sel_cnt = 0, wd_cnt = 0, rst_cnt = 0, miso_hi = 0;
    int         checks = 0, failures = 0;
    int         s_sel, s_wd, s_rst, s_mh;

    spi_slave_frontend #(.N(8), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_flag(reset_flag), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .sr_so(sr_so), .sr_sel(sr_sel),
        .sr_si(sr_si), .sr_reset(sr_reset), .active(active), .word_done(word_done),
        .word_count(word_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign sr_so = sr_q[7];

    always @(posedge clk) begin
        if (sr_reset) sr_q <= preload;
        else if (sr_sel) sr_q <= {sr_q[6:0], sr_si};
        if (sr_sel) begin
            sel_cnt <= sel_cnt + 1;
            si_log  <= {si_log[6:0], sr_si};
        end
        if (word_done) wd_cnt <= wd_cnt + 1;
        if (sr_reset) rst_cnt <= rst_cnt + 1;
        if (spi_miso) miso_hi <= miso_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_sel = sel_cnt; s_wd = wd_cnt; s_rst = rst_cnt; s_mh = miso_hi;
    endtask

    task automatic spi_bit(input logic b, input int h, input bit lat);
        spi_mosi = b;
        wt(h);
        miso_log = {miso_log[6:0], spi_miso};
        spi_sck = 1'b1;
        if (lat) begin
            wt(S);
            chk("latency_early", 32'(sr_sel), 32'd0);
            wt(1);
            chk("latency_sel", 32'(sr_sel), 32'd1);
            wt(1);
            chk("sel_one_cycle", 32'(sr_sel), 32'd0);
            wt(h - S - 2);
        end else wt(h);
        spi_sck = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        wt(3);
        chk("reset_outputs", {24'd0, sr_sel, sr_si, sr_reset, active, word_done, frame_err, spi_miso, 1'b0}, 32'd0);
        chk("reset_word_count", 32'(word_count), 32'd0);
        reset_flag = 1'b0;
        wt(10);

        snap();
        repeat (3) begin
            spi_sck = 1'b1; wt(8); spi_sck = 1'b0; wt(8);
        end
        chk("idle_sel", 32'(sel_cnt - s_sel), 32'd0);
        chk("idle_srst", 32'(rst_cnt - s_rst), 32'd0);
        chk("idle_miso", 32'(miso_hi - s_mh), 32'd0);
        chk("idle_active", 32'(active), 32'd0);

        preload = 8'h3C;
        snap();
        spi_cs_n = 1'b0;
        wt(8);
        chk("start_active", 32'(active), 32'd1);
        chk("start_srst", 32'(rst_cnt - s_rst), 32'd1);
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) spi_bit(w[i], 8, i == 7);
        wt(4);
        chk("word_si", 32'(si_log), 32'hA5);
        chk("word_miso", 32'(miso_log), 32'h3C);
        chk("word_sel", 32'(sel_cnt - s_sel), 32'd8);
        chk("word_done", 32'(wd_cnt - s_wd), 32'd1);
        chk("word_count", 32'(word_count), 32'd1);
        spi_cs_n = 1'b1;
        wt(8);
        chk("end_active", 32'(active), 32'd0);
        chk("end_ferr", 32'(frame_err), 32'd0);

        spi_cs_n = 1'b0;
        wt(8);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 8, 0);
        spi_cs_n = 1'b1;
        wt(8);
        chk("abort_ferr", 32'(frame_err), 32'd1);
        chk("abort_active", 32'(active), 32'd0);
        spi_cs_n = 1'b0;
        wt(8);
        chk("abort_ferr_clear", 32'(frame_err), 32'd0);
        chk("abort_restart", 32'(active), 32'd1);
        spi_cs_n = 1'b1;
        wt(8);

        spi_cs_n = 1'b0;
        wt(8);
        snap();
        for (int k = 0; k < 300; k++) begin
            w = 8'(k);
            for (int i = 7; i >= 0; i--) spi_bit(w[i], 6, 0);
            if (k == 254) chk("sat_reach", 32'(word_count), 32'd255);
        end
        wt(4);
        chk("sat_hold", 32'(word_count), 32'd255);
        chk("sat_done", 32'(wd_cnt - s_wd), 32'd300);
        spi_cs_n = 1'b1;
        wt(8);
        chk("sat_ferr", 32'(frame_err), 32'd0);

        spi_cs_n = 1'b0;
        wt(8);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 8, 0);
        reset_flag = 1'b1;
        wt(2);
        reset_flag = 1'b0;
        wt(1);
        chk("rst_mid_active", 32'(active), 32'd0);
        chk("rst_mid_wc", 32'(word_count), 32'd0);
        wt(10);
        snap();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 8, 0);
        chk("rst_mid_nosel", 32'(sel_cnt - s_sel), 32'd0);
        chk("rst_mid_nosrst", 32'(rst_cnt - s_rst), 32'd0);
        chk("rst_mid_inactive", 32'(active), 32'd0);
        spi_cs_n = 1'b1;
        wt(8);
        spi_cs_n = 1'b0;
        wt(8);
        chk("rst_mid_restart", 32'(active), 32'd1);
        snap();
        spi_bit(1'b0, 8, 0);
        chk("rst_mid_sel", 32'(sel_cnt - s_sel), 32'd1);
        spi_cs_n = 1'b1;
        wt(8);
        chk("rst_mid_ferr", 32'(frame_err), 32'd1);

        snap();
        spi_cs_n = 1'b0;
        spi_sck  = 1'b1;
        wt(8);
        chk("cs_wins_active", 32'(active), 32'd1);
        chk("cs_wins_nosel", 32'(sel_cnt - s_sel), 32'd0);
        spi_sck = 1'b0;
        wt(8);
        snap();
        spi_sck = 1'b1;
        wt(1);
        spi_sck = 1'b0;
        wt(10);
`ifdef SPI_SCK_FILTER_EN
        chk("glitch_sel", 32'(sel_cnt - s_sel), 32'd0);
`else
        chk("glitch_sel", 32'(sel_cnt - s_sel), 32'd1);
`endif
        spi_cs_n = 1'b1;
        wt(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
